truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 88 ++++++++
 tb/tb_truth_table_sweeper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Sweeps an N-input combinational block through every input value,
//            captures its output into a truth table and counts the ones.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int N_INPUTS    = 5,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [N_INPUTS-1:0]      vec,
    input  logic                     f_in,
    output logic                     busy,
    output logic                     done,
    output logic [2**N_INPUTS-1:0]   table_out,
    output logic [N_INPUTS:0]        ones_count
);

    localparam logic [3:0]          c_HOLD = 4'(HOLD_CYCLES);
    localparam logic [N_INPUTS-1:0] c_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_hold;

    logic [N_INPUTS:0] w_inc;
    assign w_inc = {{N_INPUTS{1'b0}}, f_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold     <= 4'd0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_hold     <= 4'd0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        table_out  <= '0;
                        ones_count <= '0;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here; a sweep always runs to completion
                    if (r_hold < c_HOLD) begin
                        r_hold <= r_hold + 4'd1;
                    end else begin
                        table_out[vec] <= f_in;
                        ones_count     <= ones_count + w_inc;
                        r_hold         <= 4'd0;
                        if (vec == c_LAST) begin
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 4'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Bench for truth_table_sweeper with HOLD_CYCLES of 0, 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  start_v = 3'b000;
    logic [31:0] truth = 32'h0;

    logic [4:0]  vec0, vec1, vec3;
    logic        busy0, busy1, busy3, done0, done1, done3;
    logic [31:0] tab0, tab1, tab3;
    logic [5:0]  ones0, ones1, ones3;
    logic        f0, f1, f3;

    // Downstream block for the HOLD=3 instance: output lags vec by 3 cycles
    logic [4:0]  vd1 = 5'd0, vd2 = 5'd0, vd3 = 5'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;
    int sel      = 0;

    logic [4:0]  m_vec;
    logic        m_busy, m_done;
    logic [31:0] m_tab;
    logic [5:0]  m_ones;

    always #5 clk = ~clk;

    assign f0 = truth[vec0];
    assign f1 = truth[vec1];
    assign f3 = truth[vd3];

    always @(posedge clk) begin
        vd1 <= vec3;
        vd2 <= vd1;
        vd3 <= vd2;
    end

    always @(negedge clk) begin
        if ((busy0 && done0) || (busy1 && done1) || (busy3 && done3))
            overlap = overlap + 1;
    end

    always_comb begin
        m_vec = vec1; m_busy = busy1; m_done = done1; m_tab = tab1; m_ones = ones1;
        case (sel)
            0: begin m_vec = vec0; m_busy = busy0; m_done = done0; m_tab = tab0; m_ones = ones0; end
            2: begin m_vec = vec3; m_busy = busy3; m_done = done3; m_tab = tab3; m_ones = ones3; end
            default: ;
        endcase
    end

    truth_table_sweeper #(.N_INPUTS(5), .HOLD_CYCLES(0)) u_h0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .vec(vec0), .f_in(f0),
        .busy(busy0), .done(done0), .table_out(tab0), .ones_count(ones0));

    truth_table_sweeper #(.N_INPUTS(5), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .vec(vec1), .f_in(f1),
        .busy(busy1), .done(done1), .table_out(tab1), .ones_count(ones1));

    truth_table_sweeper #(.N_INPUTS(5), .HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .reset(reset), .start(start_v[2]), .vec(vec3), .f_in(f3),
        .busy(busy3), .done(done3), .table_out(tab3), .ones_count(ones3));

    // Stimulus helpers only; they make no comparisons.
    task automatic launch(input int s);
        sel = s;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        while (!m_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        to = !m_done;
    endtask

    task automatic wait_vec(input logic [4:0] v, output int cyc, output bit to);
        cyc = 0;
        while (m_vec != v && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        to = (m_vec != v);
    endtask

    function automatic logic [31:0] rand_truth();
        return $urandom;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if ({m_busy, m_done, m_vec, m_tab, m_ones} !== 45'd0) begin
                n_fail++;
                $display("FAIL reset_state sel=%0d: busy=%b done=%b vec=%0d table=%h ones=%0d, required all zero",
                         s, m_busy, m_done, m_vec, m_tab, m_ones);
            end
        end
    endtask

    task automatic test_xor_hold1();
        int  cyc;
        bit  to;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] iv;
            iv = i[4:0];
            truth[i] = ^iv;
        end
        launch(1);
        n_checks++;
        if (m_busy !== 1'b1 || m_done !== 1'b0 || m_vec !== 5'd0 || m_tab !== 32'd0) begin
            n_fail++;
            $display("FAIL xor_launch: busy=%b done=%b vec=%0d table=%h, required 1 0 0 0",
                     m_busy, m_done, m_vec, m_tab);
        end
        wait_done(cyc, to);
        n_checks++;
        if (to || cyc != 64) begin
            n_fail++;
            $display("FAIL xor_latency: got %0d cycles (timeout=%b), required 64", cyc, to);
        end
        n_checks++;
        if (m_tab !== 32'h96696996 || m_ones !== 6'd16) begin
            n_fail++;
            $display("FAIL xor_table: table=%h ones=%0d, required 96696996 16", m_tab, m_ones);
        end
        n_checks++;
        if (m_busy !== 1'b0 || m_vec !== 5'd31) begin
            n_fail++;
            $display("FAIL xor_done_state: busy=%b vec=%0d, required 0 31", m_busy, m_vec);
        end
    endtask

    task automatic test_msb_hold0();
        bit step_ok;
        for (int i = 0; i < 32; i++) truth[i] = (i >= 16);
        launch(0);
        step_ok = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (m_vec !== 5'(c) || m_busy !== 1'b1 || m_done !== 1'b0) step_ok = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!step_ok) begin
            n_fail++;
            $display("FAIL msb_vec_step: got step_ok=%b, required 1 (vec +1 per cycle while busy)", step_ok);
        end
        n_checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_latency: done=%b busy=%b after 32 cycles, required 1 0", m_done, m_busy);
        end
        n_checks++;
        if (m_tab !== 32'hFFFF0000 || m_ones !== 6'd16) begin
            n_fail++;
            $display("FAIL msb_table: table=%h ones=%0d, required ffff0000 16", m_tab, m_ones);
        end
    endtask

    task automatic test_constants();
        int cyc;
        bit to;
        for (int k = 0; k < 2; k++) begin
            truth = (k == 0) ? 32'h0 : 32'hFFFF_FFFF;
            launch(1);
            wait_done(cyc, to);
            n_checks++;
            if (to || m_tab !== truth || m_ones !== ((k == 0) ? 6'd0 : 6'd32)) begin
                n_fail++;
                $display("FAIL const_%0d: table=%h ones=%0d timeout=%b, required %h %0d",
                         k, m_tab, m_ones, to, truth, (k == 0) ? 0 : 32);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        bit to;
        for (int r = 0; r < 3; r++) begin
            truth = rand_truth();
            launch(1);
            wait_done(cyc, to);
            n_checks++;
            if (to || m_tab !== truth || m_ones !== 6'($countones(truth))) begin
                n_fail++;
                $display("FAIL random_%0d: table=%h ones=%0d, required %h %0d",
                         r, m_tab, m_ones, truth, $countones(truth));
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit to;
        truth = rand_truth() | 32'h0000_0001;
        launch(1);
        wait_vec(5'd10, cyc, to);
        n_checks++;
        if (to || m_tab[31:10] !== 22'd0 || m_tab[9:0] !== truth[9:0]) begin
            n_fail++;
            $display("FAIL partial_table: table=%h timeout=%b, required low10=%h high=0",
                     m_tab, to, truth[9:0]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({m_busy, m_done, m_vec, m_tab, m_ones} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b vec=%0d table=%h ones=%0d, required all zero",
                     m_busy, m_done, m_vec, m_tab, m_ones);
        end
        truth = rand_truth();
        launch(1);
        wait_done(cyc, to);
        n_checks++;
        if (to || cyc != 64 || m_tab !== truth || m_ones !== 6'($countones(truth))) begin
            n_fail++;
            $display("FAIL after_reset_sweep: cyc=%0d table=%h ones=%0d, required 64 %h %0d",
                     cyc, m_tab, m_ones, truth, $countones(truth));
        end
    endtask

    task automatic test_back_to_back();
        int cyc, total;
        bit to;
        truth = rand_truth();
        launch(1);
        wait_vec(5'd7, cyc, to);
        total = cyc;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        total++;
        n_checks++;
        if (to || m_vec !== 5'd7 || m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_run: vec=%0d busy=%b, required 7 1", m_vec, m_busy);
        end
        wait_done(cyc, to);
        total += cyc;
        n_checks++;
        if (to || total != 64 || m_tab !== truth) begin
            n_fail++;
            $display("FAIL start_in_run_sweep: total=%0d table=%h, required 64 %h", total, m_tab, truth);
        end
        truth = rand_truth();
        launch(1);
        n_checks++;
        if (m_done !== 1'b0 || m_busy !== 1'b1 || m_vec !== 5'd0 || m_tab !== 32'd0 || m_ones !== 6'd0) begin
            n_fail++;
            $display("FAIL relaunch: done=%b busy=%b vec=%0d table=%h ones=%0d, required 0 1 0 0 0",
                     m_done, m_busy, m_vec, m_tab, m_ones);
        end
        wait_done(cyc, to);
        n_checks++;
        if (to || m_tab !== truth || m_ones !== 6'($countones(truth))) begin
            n_fail++;
            $display("FAIL relaunch_sweep: table=%h ones=%0d, required %h %0d",
                     m_tab, m_ones, truth, $countones(truth));
        end
    endtask

    task automatic test_hold3_delayed();
        int cyc;
        bit to;
        for (int r = 0; r < 2; r++) begin
            truth = rand_truth();
            launch(2);
            wait_done(cyc, to);
            n_checks++;
            if (to || cyc != 128 || m_tab !== truth || m_ones !== 6'($countones(truth))) begin
                n_fail++;
                $display("FAIL hold3_%0d: cyc=%0d table=%h ones=%0d, required 128 %h %0d",
                         r, cyc, m_tab, m_ones, truth, $countones(truth));
            end
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL busy_done_overlap: got %0d cycles, required 0", overlap);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_xor_hold1();
        test_msb_hold0();
        test_constants();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_hold3_delayed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
